// File: rtl/fir_out_decim.sv
// -----------------------------------------------------------------------------
// fir_out_decim
//   Output stage behind the FIR in the fixed-point WLO datapath. It takes
//   one filter word per in_valid strobe and quantises it to a narrower
//   format using round-half-up and saturation. It keeps every DECIM-th
//   sample. Kept words are queued in a small fall-through FIFO with a
//   valid/ready handshake, so the fixed-rate FIR can feed a consumer that
//   stalls. Overflow and saturation events are reported for word-length
//   analysis.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clr_flags  synchronous clear of overflow and sat_cnt
//   data_in    signed Q(IN_INTE_WL).(IN_FRAC_WL) sample
//   in_valid   sample strobe; no backpressure toward the FIR
//   data_out   signed Q(OUT_INTE_WL).(OUT_FRAC_WL) FIFO head (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head at this edge
//   fill       number of stored words, 0..DEPTH
//   overflow   sticky: a kept sample was dropped because the FIFO was full
//   sat_cnt    count of clipped kept samples; holds at 0xFFFF
// -----------------------------------------------------------------------------
module fir_out_decim #(
   parameter int IN_INTE_WL  = 4,
   parameter int IN_FRAC_WL  = 8,
   parameter int OUT_INTE_WL = 2,
   parameter int OUT_FRAC_WL = 6,
   parameter int DECIM       = 2,
   parameter int DEPTH       = 4
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     clr_flags,
   input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0]  data_in,
   input  logic                                     in_valid,
   output logic signed [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [$clog2(DEPTH):0]                   fill,
   output logic                                     overflow,
   output logic [15:0]                              sat_cnt
);

   localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
   localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int SHL   = (OUT_FRAC_WL > IN_FRAC_WL) ? OUT_FRAC_WL - IN_FRAC_WL : 0;
   // One guard bit above the input width keeps the rounding add from wrapping.
   localparam int WQ    = IN_W + 1 + SHL;

   localparam logic signed [WQ-1:0] MAXV = {{(WQ-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WQ-1:0] MINV = {{(WQ-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [PW-1:0]        PHASE_LAST = PW'(DECIM - 1);
   localparam logic [AW:0]          FILL_MAX   = (AW+1)'(DEPTH);

   // ---------------- quantiser ----------------
   logic signed [WQ-1:0] q_wide;

   generate
      if (OUT_FRAC_WL < IN_FRAC_WL) begin : g_round
         localparam int S = IN_FRAC_WL - OUT_FRAC_WL;
         localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (S - 1);
         logic signed [IN_W:0] ext;
         logic signed [IN_W:0] sum;
         assign ext    = {data_in[IN_W-1], data_in};
         assign sum    = ext + HALF;
         assign q_wide = sum >>> S;
      end else begin : g_pad
         logic signed [WQ-1:0] ext;
         assign ext    = {{(SHL+1){data_in[IN_W-1]}}, data_in};
         assign q_wide = ext <<< SHL;
      end
   endgenerate

   logic             clip_hi;
   logic             clip_lo;
   logic [OUT_W-1:0] q_sat;

   assign clip_hi = (q_wide > MAXV);
   assign clip_lo = (q_wide < MINV);
   assign q_sat   = clip_hi ? MAXV[OUT_W-1:0] :
                    clip_lo ? MINV[OUT_W-1:0] : q_wide[OUT_W-1:0];

   // ---------------- state ----------------
   logic [PW-1:0]    phase_reg,    phase_next;
   logic             s1_valid_reg, s1_valid_next;
   logic [OUT_W-1:0] s1_data_reg;
   logic [AW-1:0]    wr_ptr_reg,   wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg,   rd_ptr_next;
   logic [AW:0]      fill_reg,     fill_next;
   logic             overflow_reg, overflow_next;
   logic [15:0]      sat_cnt_reg,  sat_cnt_next;
   logic [OUT_W-1:0] mem [DEPTH];

   logic kept;
   logic sat_evt;
   logic pop;
   logic push_ok;
   logic ovf_evt;

   assign kept    = in_valid && (phase_reg == '0);
   assign sat_evt = kept && (clip_hi || clip_lo);
   assign pop     = out_valid && out_ready;
   // A full FIFO still takes the word when the head leaves at the same edge.
   assign push_ok = s1_valid_reg && ((fill_reg != FILL_MAX) || pop);
   assign ovf_evt = s1_valid_reg && !push_ok;

   always_comb begin
      phase_next    = phase_reg;
      s1_valid_next = kept;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      fill_next     = fill_reg;
      overflow_next = overflow_reg;
      sat_cnt_next  = sat_cnt_reg;

      if (in_valid)
         phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + PW'(1);

      if (push_ok)
         wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)
         rd_ptr_next = rd_ptr_reg + AW'(1);

      case ({push_ok, pop})
         2'b10:   fill_next = fill_reg + (AW+1)'(1);
         2'b01:   fill_next = fill_reg - (AW+1)'(1);
         default: fill_next = fill_reg;
      endcase

      // Clear first so that a same-edge event still registers.
      if (clr_flags) begin
         overflow_next = 1'b0;
         sat_cnt_next  = '0;
      end
      if (ovf_evt)
         overflow_next = 1'b1;
      if (sat_evt)
         sat_cnt_next = clr_flags ? 16'd1 :
                        (sat_cnt_reg == 16'hFFFF) ? sat_cnt_reg : sat_cnt_reg + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg    <= '0;
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fill_reg     <= '0;
         overflow_reg <= 1'b0;
         sat_cnt_reg  <= '0;
      end else begin
         phase_reg    <= phase_next;
         s1_valid_reg <= s1_valid_next;
         s1_data_reg  <= q_sat;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         fill_reg     <= fill_next;
         overflow_reg <= overflow_next;
         sat_cnt_reg  <= sat_cnt_next;
      end
   end

   // Storage array has no reset; the pointers and fill define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         mem[wr_ptr_reg] <= s1_data_reg;
   end

   // Fall-through head: the word written at an edge is visible right after it.
   assign out_valid = (fill_reg != '0);
   assign data_out  = out_valid ? mem[rd_ptr_reg] : '0;
   assign fill      = fill_reg;
   assign overflow  = overflow_reg;
   assign sat_cnt   = sat_cnt_reg;

endmodule

// File: tb/tb_fir_out_decim.sv
module tb_fir_out_decim;

   typedef int arr6_t [6];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               clr_flags;
   logic               in_valid;
   logic               out_ready;
   logic signed [11:0] data_in;

   logic signed [7:0]  dout [2];
   logic               ov   [2];
   logic [2:0]         fill [2];
   logic               ovf  [2];
   logic [15:0]        satc [2];

   fir_out_decim #(.IN_INTE_WL(4), .IN_FRAC_WL(8), .OUT_INTE_WL(2), .OUT_FRAC_WL(6),
                   .DECIM(1), .DEPTH(4)) u_d1 (
      .clk(clk), .rst(rst), .clr_flags(clr_flags), .data_in(data_in), .in_valid(in_valid),
      .data_out(dout[0]), .out_valid(ov[0]), .out_ready(out_ready), .fill(fill[0]),
      .overflow(ovf[0]), .sat_cnt(satc[0]));

   fir_out_decim #(.IN_INTE_WL(4), .IN_FRAC_WL(8), .OUT_INTE_WL(2), .OUT_FRAC_WL(6),
                   .DECIM(2), .DEPTH(4)) u_d2 (
      .clk(clk), .rst(rst), .clr_flags(clr_flags), .data_in(data_in), .in_valid(in_valid),
      .data_out(dout[1]), .out_valid(ov[1]), .out_ready(out_ready), .fill(fill[1]),
      .overflow(ovf[1]), .sat_cnt(satc[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Round-half-up from Q4.8 to Q2.6 with clamp to the 8-bit range.
   function automatic int quant(input int x, output bit clip);
      int r;
      r = (x + 2) >>> 2;
      clip = 1'b0;
      if (r > 127) begin r = 127; clip = 1'b1; end
      else if (r < -128) begin r = -128; clip = 1'b1; end
      return r;
   endfunction

   // ---------------- behavioural model (one per instance) ----------------
   int mq     [2][$];
   bit pend_v [2];
   int pend_w [2];
   bit m_ovf  [2];
   int m_sat  [2];
   int m_cnt  [2];
   int decim_of [2] = '{1, 2};
   bit model_live = 1'b0;

   // Words actually taken by the consumer, for literal order checks.
   int log_q [2][$];

   always @(posedge clk) begin
      int  w;
      bit  c;
      bit  keep;
      bit  ovf_e;
      for (int k = 0; k < 2; k++) begin
         if (!rst && ov[k] && out_ready)
            log_q[k].push_back(int'(dout[k]));
         if (rst) begin
            mq[k].delete();
            pend_v[k] = 1'b0;
            m_ovf[k]  = 1'b0;
            m_sat[k]  = 0;
            m_cnt[k]  = 0;
         end else begin
            ovf_e = 1'b0;
            if (mq[k].size() > 0 && out_ready)
               void'(mq[k].pop_front());
            if (pend_v[k]) begin
               if (mq[k].size() < 4) mq[k].push_back(pend_w[k]);
               else ovf_e = 1'b1;
            end
            w    = quant(int'(data_in), c);
            keep = in_valid && (m_cnt[k] % decim_of[k] == 0);
            pend_v[k] = keep;
            pend_w[k] = w;
            if (in_valid) m_cnt[k]++;
            if (clr_flags) begin m_ovf[k] = 1'b0; m_sat[k] = 0; end
            if (ovf_e) m_ovf[k] = 1'b1;
            if (keep && c) m_sat[k] = clr_flags ? 1 : ((m_sat[k] >= 65535) ? 65535 : m_sat[k] + 1);
         end
      end
      if (rst) model_live = 1'b1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("m_valid%0d", k), int'(ov[k]), (mq[k].size() > 0) ? 1 : 0);
            chk($sformatf("m_fill%0d", k), int'(fill[k]), mq[k].size());
            chk($sformatf("m_data%0d", k), int'(dout[k]), (mq[k].size() > 0) ? mq[k][0] : 0);
            chk($sformatf("m_ovf%0d", k), int'(ovf[k]), int'(m_ovf[k]));
            chk($sformatf("m_sat%0d", k), int'(satc[k]), m_sat[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      in_valid = 1'b1;
      data_in  = 12'(v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic chk_log(input string nm, input int k, input int n, input arr6_t e);
      chk({nm, "_len"}, log_q[k].size(), n);
      for (int i = 0; i < n && i < log_q[k].size(); i++)
         chk($sformatf("%s_w%0d", nm, i), log_q[k][i], e[i]);
   endtask

   task automatic clear_logs();
      log_q[0].delete();
      log_q[1].delete();
   endtask

   initial begin
      arr6_t e;
      bit    c;
      rst = 1'b1; clr_flags = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
      step(); step();
      chk("rst_fill", int'(fill[0]), 0);
      chk("rst_valid", int'(ov[0]), 0);
      chk("rst_data", int'(dout[0]), 0);
      rst = 1'b0;

      // Pin the model's quantiser with hand-worked values.
      chk("q_5",     quant(5, c), 1);
      chk("q_m6",    quant(-6, c), -1);
      chk("q_6",     quant(6, c), 2);
      chk("q_m7",    quant(-7, c), -2);
      chk("q_2047",  quant(2047, c), 127);
      chk("q_m2048", quant(-2048, c), -128);

      // 1: rounding and 2-cycle latency
      clear_logs();
      out_ready = 1'b0;
      send(5);
      chk("lat_e0_valid", int'(ov[0]), 0);
      send(-6);
      chk("lat_e1_valid", int'(ov[0]), 1);
      chk("lat_e1_data", int'(dout[0]), 1);
      send(6);
      send(-7);
      idle(2);
      chk("t1_fill", int'(fill[0]), 4);
      out_ready = 1'b1;
      idle(5);
      out_ready = 1'b0;
      e = '{1, -1, 2, -2, 0, 0};  chk_log("t1_d1", 0, 4, e);
      e = '{1, 2, 0, 0, 0, 0};    chk_log("t1_d2", 1, 2, e);
      chk("t1_sat", int'(satc[0]), 0);

      // 2: saturation
      clear_logs();
      out_ready = 1'b1;
      send(2047);
      send(-2048);
      idle(4);
      e = '{127, -128, 0, 0, 0, 0}; chk_log("t2_d1", 0, 2, e);
      chk("t2_sat_d1", int'(satc[0]), 2);
      chk("t2_sat_d2", int'(satc[1]), 1);

      // 3: decimation
      clear_logs();
      for (int v = 4; v <= 24; v += 4) send(v);
      idle(4);
      e = '{1, 3, 5, 0, 0, 0};    chk_log("t3_d2", 1, 3, e);
      e = '{1, 2, 3, 4, 5, 6};    chk_log("t3_d1", 0, 6, e);

      // 4a: full FIFO, overflow
      clear_logs();
      out_ready = 1'b0;
      for (int v = 40; v <= 60; v += 4) send(v);
      idle(2);
      chk("t4_fill", int'(fill[0]), 4);
      chk("t4_ovf", int'(ovf[0]), 1);
      chk("t4_ovf_d2", int'(ovf[1]), 0);
      out_ready = 1'b1;
      idle(5);
      out_ready = 1'b0;
      e = '{10, 11, 12, 13, 0, 0}; chk_log("t4_d1", 0, 4, e);
      e = '{10, 12, 14, 0, 0, 0};  chk_log("t4_d2", 1, 3, e);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("t4_clr_ovf", int'(ovf[0]), 0);
      chk("t4_clr_sat", int'(satc[0]), 0);

      // 4b: pops on the edges of the 5th and 6th pushes avoid overflow
      clear_logs();
      for (int v = 40; v <= 56; v += 4) send(v);
      out_ready = 1'b1;
      send(60);
      step();
      out_ready = 1'b0;
      chk("t4b_fill", int'(fill[0]), 4);
      chk("t4b_ovf", int'(ovf[0]), 0);
      out_ready = 1'b1;
      idle(5);
      out_ready = 1'b0;
      e = '{10, 11, 12, 13, 14, 15}; chk_log("t4b_d1", 0, 6, e);

      // 5: reset mid-operation
      clear_logs();
      send(2047);
      send(8);
      send(12);
      send(16);
      chk("t5_pre_fill", int'(fill[0]), 3);
      chk("t5_pre_sat", int'(satc[0]), 1);
      rst = 1'b1; in_valid = 1'b1; data_in = 12'd100;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("t5_fill", int'(fill[0]), 0);
      chk("t5_valid", int'(ov[0]), 0);
      chk("t5_ovf", int'(ovf[0]), 0);
      chk("t5_sat", int'(satc[0]), 0);
      chk("t5_fill_d2", int'(fill[1]), 0);
      send(8);
      step();
      chk("t5_next_d2_valid", int'(ov[1]), 1);
      chk("t5_next_d2_data", int'(dout[1]), 2);
      chk("t5_next_d1_fill", int'(fill[0]), 1);
      out_ready = 1'b1;
      idle(2);

      // 6: clr_flags coincident with a saturating kept sample
      send(2047);
      send(2047);
      idle(1);
      chk("t6_pre_sat_d1", int'(satc[0]), 2);
      chk("t6_pre_sat_d2", int'(satc[1]), 1);
      clr_flags = 1'b1;
      send(2047);
      clr_flags = 1'b0;
      chk("t6_sat_d1", int'(satc[0]), 1);
      chk("t6_sat_d2", int'(satc[1]), 0);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
